// File: rtl/room_controller.sv
// Room sequencer: detects screen-edge exits, fades to black,
// swaps the active room and repositions the player.
module room_controller #(
    parameter int FADE_FRAMES = 2,
    parameter int EDGE        = 8
) (
    input  logic       clk_vga,
    input  logic       rst,
    input  logic       frame_start,
    input  logic [9:0] playerX,
    input  logic [8:0] playerY,
    input  logic [7:0] room0Data,
    input  logic [7:0] room1Data,
    input  logic [7:0] room2Data,
    input  logic [7:0] room3Data,
    output logic [7:0] mapData,
    output logic [7:0] wall,
    output logic [1:0] room,
    output logic       player_load,
    output logic [9:0] load_X,
    output logic [8:0] load_Y,
    output logic       busy
);

    localparam int CW = $clog2(FADE_FRAMES + 1);

    localparam logic [8:0] Y_TOP   = 9'(EDGE);
    localparam logic [8:0] Y_BOT   = 9'(480 - EDGE);
    localparam logic [9:0] X_LEFT  = 10'(EDGE);
    localparam logic [9:0] X_RIGHT = 10'(640 - EDGE);

    localparam logic [CW-1:0] CNT_LAST = CW'(FADE_FRAMES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FADE_FRAMES);

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        FADE_OUT = 2'd1,
        SWITCH   = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    state_t        state;
    state_t        nextState;
    logic [CW-1:0] fadeCnt;
    logic [1:0]    targetRoom;
    dir_t          targetDir;

    logic          exitHit;
    dir_t          exitDir;
    logic          nbValid;
    logic [1:0]    nbRoom;
    logic          startFade;
    logic          enterSwitch;
    logic [7:0]    roomSel;

    // Edge-zone decode; the first matching zone in priority order wins
    always_comb begin
        exitHit = 1'b1;
        exitDir = DIR_UP;
        priority case (1'b1)
            (playerY < Y_TOP):    exitDir = DIR_UP;
            (playerY >= Y_BOT):   exitDir = DIR_DOWN;
            (playerX < X_LEFT):   exitDir = DIR_LEFT;
            (playerX >= X_RIGHT): exitDir = DIR_RIGHT;
            default:              exitHit = 1'b0;
        endcase
    end

    // Fixed map topology: which room lies beyond each exit
    always_comb begin
        nbValid = 1'b0;
        nbRoom  = room;
        case ({room, exitDir})
            {2'd0, DIR_UP}: begin
                nbValid = 1'b1;
                nbRoom  = 2'd1;
            end
            {2'd1, DIR_DOWN}: begin
                nbValid = 1'b1;
                nbRoom  = 2'd0;
            end
            {2'd1, DIR_UP}: begin
                nbValid = 1'b1;
                nbRoom  = 2'd2;
            end
            {2'd2, DIR_DOWN}: begin
                nbValid = 1'b1;
                nbRoom  = 2'd1;
            end
            {2'd2, DIR_RIGHT}: begin
                nbValid = 1'b1;
                nbRoom  = 2'd3;
            end
            {2'd3, DIR_LEFT}: begin
                nbValid = 1'b1;
                nbRoom  = 2'd2;
            end
            default: begin
                nbValid = 1'b0;
                nbRoom  = room;
            end
        endcase
    end

    assign startFade   = (state == PLAY) && frame_start
                         && exitHit && nbValid;
    assign enterSwitch = (state == FADE_OUT) && frame_start
                         && (fadeCnt == CNT_LAST);

    // State register
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) state <= PLAY;
        else     state <= nextState;
    end

    // Next-state logic; a pulse that ends FADE_OUT is not seen by FADE_IN
    always_comb begin
        nextState = state;
        unique case (state)
            PLAY:     if (startFade)   nextState = FADE_OUT;
            FADE_OUT: if (enterSwitch) nextState = SWITCH;
            SWITCH:                    nextState = FADE_IN;
            FADE_IN:  if (frame_start) nextState = PLAY;
            default:                   nextState = PLAY;
        endcase
    end

    // Outputs decoded from state alone
    always_comb begin
        busy = (state != PLAY);
    end

    // Fade counter: clears on fade start, saturates instead of wrapping
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            fadeCnt <= '0;
        end else if (startFade) begin
            fadeCnt <= '0;
        end else if (state == FADE_OUT && frame_start
                     && fadeCnt != CNT_MAX) begin
            fadeCnt <= fadeCnt + 1'b1;
        end
    end

    // Latch destination when a transition is committed
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            targetRoom <= 2'd0;
            targetDir  <= DIR_UP;
        end else if (startFade) begin
            targetRoom <= nbRoom;
            targetDir  <= exitDir;
        end
    end

    // Room swap and player reposition land together in the SWITCH cycle
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            room        <= 2'd0;
            player_load <= 1'b0;
            load_X      <= '0;
            load_Y      <= '0;
        end else begin
            player_load <= enterSwitch;
            if (enterSwitch) begin
                room <= targetRoom;
                unique case (targetDir)
                    DIR_UP: begin
                        load_X <= playerX;
                        load_Y <= 9'd432;
                    end
                    DIR_DOWN: begin
                        load_X <= playerX;
                        load_Y <= 9'd48;
                    end
                    DIR_LEFT: begin
                        load_X <= 10'd592;
                        load_Y <= playerY;
                    end
                    DIR_RIGHT: begin
                        load_X <= 10'd48;
                        load_Y <= playerY;
                    end
                    default: begin
                        load_X <= playerX;
                        load_Y <= playerY;
                    end
                endcase
            end
        end
    end

    // Active room's renderer colour
    always_comb begin
        roomSel = room0Data;
        unique case (room)
            2'd0:    roomSel = room0Data;
            2'd1:    roomSel = room1Data;
            2'd2:    roomSel = room2Data;
            2'd3:    roomSel = room3Data;
            default: roomSel = room0Data;
        endcase
    end

    // Pixel register; black whenever the coming state is not PLAY
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst)                    mapData <= 8'h00;
        else if (nextState == PLAY) mapData <= roomSel;
        else                        mapData <= 8'h00;
    end

    // Per-room wall palette
    always_comb begin
        wall = 8'hFC;
        unique case (room)
            2'd0:    wall = 8'hFC;
            2'd1:    wall = 8'h00;
            2'd2:    wall = 8'h1F;
            2'd3:    wall = 8'hE0;
            default: wall = 8'hFC;
        endcase
    end

endmodule

// File: tb/tb_room_controller.sv
// Directed bench for room_controller: exits, fades, room swaps,
// player reload and reset during a fade.
module tb_room_controller;

    logic       clk_vga;
    logic       rst;
    logic       frame_start;
    logic [9:0] playerX;
    logic [8:0] playerY;
    logic [7:0] room0Data;
    logic [7:0] room1Data;
    logic [7:0] room2Data;
    logic [7:0] room3Data;
    logic [7:0] mapData;
    logic [7:0] wall;
    logic [1:0] room;
    logic       player_load;
    logic [9:0] load_X;
    logic [8:0] load_Y;
    logic       busy;

    int checks = 0;
    int errors = 0;

    room_controller dut (
        .clk_vga    (clk_vga),
        .rst        (rst),
        .frame_start(frame_start),
        .playerX    (playerX),
        .playerY    (playerY),
        .room0Data  (room0Data),
        .room1Data  (room1Data),
        .room2Data  (room2Data),
        .room3Data  (room3Data),
        .mapData    (mapData),
        .wall       (wall),
        .room       (room),
        .player_load(player_load),
        .load_X     (load_X),
        .load_Y     (load_Y),
        .busy       (busy)
    );

    initial clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Full exit sequence from PLAY: 1 pulse to fade, 2 counted, SWITCH, 1 to PLAY
    task automatic doExit(input string tag, input logic [1:0] expRoom,
                          input logic [9:0] expX, input logic [8:0] expY,
                          input logic [7:0] expWall, input logic [7:0] expMap);
        pulse();
        check({tag, "_fo_busy"}, 32'(busy), 32'd1);
        check({tag, "_fo_map"}, 32'(mapData), 32'h00);
        tick();
        pulse();
        check({tag, "_fo2_load"}, 32'(player_load), 32'd0);
        check({tag, "_fo2_busy"}, 32'(busy), 32'd1);
        pulse();
        check({tag, "_sw_load"}, 32'(player_load), 32'd1);
        check({tag, "_sw_room"}, 32'(room), 32'(expRoom));
        check({tag, "_sw_x"}, 32'(load_X), 32'(expX));
        check({tag, "_sw_y"}, 32'(load_Y), 32'(expY));
        check({tag, "_sw_wall"}, 32'(wall), 32'(expWall));
        check({tag, "_sw_map"}, 32'(mapData), 32'h00);
        tick();
        check({tag, "_fi_load"}, 32'(player_load), 32'd0);
        check({tag, "_fi_busy"}, 32'(busy), 32'd1);
        check({tag, "_fi_yhold"}, 32'(load_Y), 32'(expY));
        tick();
        check({tag, "_fi_wait"}, 32'(busy), 32'd1);
        pulse();
        check({tag, "_play_busy"}, 32'(busy), 32'd0);
        check({tag, "_play_map"}, 32'(mapData), 32'(expMap));
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        playerX     = 10'd320;
        playerY     = 9'd240;
        room0Data   = 8'hB6;
        room1Data   = 8'h11;
        room2Data   = 8'h22;
        room3Data   = 8'h33;

        #12;
        check("rst_map", 32'(mapData), 32'h00);
        check("rst_room", 32'(room), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wall", 32'(wall), 32'hFC);
        check("rst_load", 32'(player_load), 32'd0);
        check("rst_lx", 32'(load_X), 32'd0);
        check("rst_ly", 32'(load_Y), 32'd0);
        rst = 1'b0;
        tick();
        check("first_map", 32'(mapData), 32'hB6);
        check("first_room", 32'(room), 32'd0);

        // LEFT from room 0 has no neighbour
        playerX = 10'd3;
        pulse();
        check("noexit_busy", 32'(busy), 32'd0);
        check("noexit_room", 32'(room), 32'd0);
        check("noexit_load", 32'(player_load), 32'd0);
        check("noexit_map", 32'(mapData), 32'hB6);
        tick();
        check("noexit_busy2", 32'(busy), 32'd0);

        // 0 UP -> 1
        playerX = 10'd320;
        playerY = 9'd5;
        doExit("up01", 2'd1, 10'd320, 9'd432, 8'h00, 8'h11);

        // Position alone does nothing; exit only taken on a pulse
        playerY = 9'd100;
        pulse();
        check("mid_busy", 32'(busy), 32'd0);
        playerY = 9'd6;
        tick();
        tick();
        tick();
        check("held_busy", 32'(busy), 32'd0);
        check("held_room", 32'(room), 32'd1);
        doExit("up12", 2'd2, 10'd320, 9'd432, 8'h1F, 8'h22);

        // DOWN beats RIGHT in the bottom-right corner of room 2
        playerX = 10'd635;
        playerY = 9'd475;
        doExit("down21", 2'd1, 10'd635, 9'd475 - 9'd427, 8'h00, 8'h11);

        // Back up to room 2, then RIGHT to 3 and LEFT back to 2
        playerX = 10'd320;
        playerY = 9'd5;
        doExit("up12b", 2'd2, 10'd320, 9'd432, 8'h1F, 8'h22);
        playerX = 10'd636;
        playerY = 9'd240;
        doExit("right23", 2'd3, 10'd48, 9'd240, 8'hE0, 8'h33);
        playerX = 10'd2;
        playerY = 9'd200;
        doExit("left32", 2'd2, 10'd592, 9'd200, 8'h1F, 8'h22);
        playerX = 10'd320;
        playerY = 9'd475;
        doExit("down21b", 2'd1, 10'd320, 9'd48, 8'h00, 8'h11);

        // Reset mid-fade from room 1
        playerY = 9'd5;
        pulse();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #2;
        check("mid_rst_room", 32'(room), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_map", 32'(mapData), 32'h00);
        check("mid_rst_wall", 32'(wall), 32'hFC);
        check("mid_rst_load", 32'(player_load), 32'd0);
        playerY = 9'd240;
        rst = 1'b0;
        tick();
        check("post_rst_map", 32'(mapData), 32'hB6);
        check("post_rst_busy", 32'(busy), 32'd0);
        room0Data = 8'h5A;
        pulse();
        check("post_rst_follow", 32'(mapData), 32'h5A);
        check("post_rst_noload", 32'(player_load), 32'd0);
        check("post_rst_room", 32'(room), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/room_controller.md
ROOM_CONTROLLER -- requirements
Module: room_controller

Interface
REQ-001 Parameter FADE_FRAMES, default 2: frames of black before the room switch.
REQ-002 Parameter EDGE, default 8: exit-zone depth in pixels from each screen edge.
REQ-003 The block SHALL have one clock and an asynchronous active-high reset, with ports as follows.
REQ-004 clk_vga  in  1  pixel clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 frame_start  in  1  one-cycle pulse at vblank start.
REQ-007 playerX  in  10  player pixel X (0-639).
REQ-008 playerY  in  9  player pixel Y (0-479).
REQ-009 room0Data, room1Data, room2Data, room3Data  in  8 each  per-room renderer color outputs.
REQ-010 mapData  out  8  selected room color, registered.
REQ-011 wall  out  8  wall color driven to all room renderers.
REQ-012 room  out  2  current room index.
REQ-013 player_load  out  1  one-cycle pulse; player module loads load_X/load_Y.
REQ-014 load_X  out  10  player X to load.
REQ-015 load_Y  out  9  player Y to load.
REQ-016 busy  out  1  high in any state other than PLAY.

Function
REQ-017 FSM states SHALL be PLAY, FADE_OUT, SWITCH and FADE_IN.
REQ-018 Exit direction SHALL be decoded combinationally from the player position:
- UP: playerY < EDGE
- DOWN: playerY >= 480-EDGE
- LEFT: playerX < EDGE
- RIGHT: playerX >= 640-EDGE
- Priority when several are true: UP > DOWN > LEFT > RIGHT.
REQ-019 The neighbor table SHALL be fixed; every pair not listed below has no neighbor:
- 0 UP -> 1
- 1 DOWN -> 0
- 1 UP -> 2
- 2 DOWN -> 1
- 2 RIGHT -> 3
- 3 LEFT -> 2
REQ-020 Exits SHALL be sampled only on the frame_start cycle while in PLAY. A valid neighbor latches the target room and direction and moves the FSM to FADE_OUT; no neighbor leaves the FSM in PLAY.
REQ-021 FADE_OUT SHALL count FADE_FRAMES frame_start pulses, then enter SWITCH on the cycle after the last pulse.
REQ-022 SWITCH SHALL last exactly one cycle. In that cycle:
- room takes the target room.
- player_load = 1.
- UP exit: load_Y = 432, load_X = playerX.
- DOWN exit: load_Y = 48, load_X = playerX.
- LEFT exit: load_X = 592, load_Y = playerY.
- RIGHT exit: load_X = 48, load_Y = playerY.
REQ-023 After SWITCH the FSM SHALL enter FADE_IN and return to PLAY on the next frame_start.
REQ-024 mapData SHALL be 8'h00 in FADE_OUT, SWITCH and FADE_IN. In PLAY it is the roomNData selected by room, registered with one clk_vga of latency.
REQ-025 wall SHALL be a combinational function of room: 0 -> 8'hFC, 1 -> 8'h00, 2 -> 8'h1F, 3 -> 8'hE0.
REQ-026 load_X and load_Y SHALL hold their last values outside SWITCH; player_load is 0 outside SWITCH.
REQ-027 The fade counter SHALL be width ceil(log2(FADE_FRAMES+1)) and SHALL NOT wrap; it clears on entry to FADE_OUT.
REQ-028 frame_start on the same cycle as the FADE_OUT exit condition SHALL be consumed by FADE_OUT only; FADE_IN waits for a later pulse.
REQ-029 Position changes outside frame_start cycles SHALL NOT affect the FSM.

Reset
REQ-030 When rst is asserted, in any state including mid-fade, the block SHALL asynchronously set:
- state = PLAY, room = 0, fade counter = 0
- mapData = 8'h00, player_load = 0
- load_X = 0, load_Y = 0
- busy = 0
- wall therefore = 8'hFC.
REQ-031 The first PLAY-mode mapData update after reset release SHALL occur on the first clk_vga edge.

Verification
REQ-032 Reset, room0Data = 8'hB6 -> after one clock mapData = 8'hB6, room = 0, wall = 8'hFC.
REQ-033 Room 0, playerY = 5, frame_start pulse -> busy = 1 and mapData = 0. After two more pulses, one player_load pulse with load_Y = 432 and room = 1. Next pulse -> PLAY.
REQ-034 Room 0, playerX = 3 (LEFT, no neighbor), frame_start -> stays in PLAY, no player_load, room = 0.
REQ-035 Room 2, playerX = 635 and playerY = 475 simultaneously, frame_start -> DOWN wins: room becomes 1, load_Y = 48.
REQ-036 rst pulsed during FADE_OUT from room 1 -> room = 0, busy = 0, no player_load, and mapData follows room0Data after release.
REQ-037 Room 1, playerY = 100 -> no frame_start response; playerY = 6 held between pulses -> transition starts only at the next frame_start.
